// File: rtl/keypad_pkg.sv
// Shared key code layout, emulator states and passcode digits for the keypad emulator and scanner.
// Digit layout follows the usual 4x4 face: rows 123A / 456B / 789C / *0#D.
package keypad_pkg;

   typedef struct packed {
      logic [1:0] row_idx;
      logic [1:0] col_idx;
   } key_code_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2
   } emu_state_t;

   localparam logic [3:0] KEY_1 = 4'b0000;
   localparam logic [3:0] KEY_2 = 4'b0001;
   localparam logic [3:0] KEY_3 = 4'b0010;
   localparam logic [3:0] KEY_4 = 4'b0100;
   localparam logic [3:0] KEY_5 = 4'b0101;
   localparam logic [3:0] KEY_6 = 4'b0110;
   localparam logic [3:0] KEY_7 = 4'b1000;
   localparam logic [3:0] KEY_8 = 4'b1001;
   localparam logic [3:0] KEY_9 = 4'b1010;
   localparam logic [3:0] KEY_0 = 4'b1101;

   // Index 0 maps to the MSB of the one-hot vector.
   function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
      return 4'b1000 >> idx;
   endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Key code FIFO: 4-bit entries, DEPTH deep (power of 2), dout shows the head combinationally.
// Latency: a push is visible on dout/count the next cycle; push when full and pop when empty are ignored.
module keypad_key_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [3:0]               din,
   output logic [3:0]               dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Keypad emulator: replays queued key codes as HOLD/GAP timed presses, answering the col strobe on row.
// row lags col by one cycle; key_ready drops while the FIFO is full; KEYPAD_EMU_BOUNCE_EN adds press chatter.
module keypad_matrix_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_CYCLES   = 16,
   parameter int GAP_CYCLES    = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int BOUNCE_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          key_valid,
   input  logic [3:0]                    key_code,
   output logic                          key_ready,
   input  logic [3:0]                    col,
   output logic [3:0]                    row,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          press_done
);

   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int FC_W    = $clog2(FIFO_DEPTH) + 1;

   if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("keypad_matrix_emulator: illegal HOLD_CYCLES/GAP_CYCLES/FIFO_DEPTH");
   end

   emu_state_t       state;
   key_code_t        cur_key;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             press_active;

   assign push = key_valid && key_ready;
   assign pop  = (state == IDLE) && !fifo_empty;
   assign busy = (state != IDLE) || (fifo_count != '0);

`ifdef KEYPAD_EMU_BOUNCE_EN
   logic [CNT_W-1:0] elapsed;

   if (BOUNCE_CYCLES >= HOLD_CYCLES) begin : g_bad_bounce
      $error("keypad_matrix_emulator: BOUNCE_CYCLES must be below HOLD_CYCLES");
   end

   // Chatter on even/odd cycles of the opening window, starting with contact made.
   assign elapsed      = CNT_W'(HOLD_CYCLES - 1) - cnt;
   assign press_active = (elapsed >= CNT_W'(BOUNCE_CYCLES)) || !elapsed[0];
`else
   if (BOUNCE_CYCLES < 0) begin : g_bad_bounce
      $error("keypad_matrix_emulator: BOUNCE_CYCLES must be non-negative");
   end

   assign press_active = 1'b1;
`endif

   keypad_key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (key_code),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_key    <= '0;
         cnt        <= '0;
         row        <= '0;
         press_done <= 1'b0;
         key_ready  <= 1'b0;
      end else begin
         press_done <= 1'b0;
         // Ready tracks the post-edge occupancy so a full FIFO never sees an extra push.
         key_ready  <= !((fifo_full && !pop) ||
                         (fifo_count == FC_W'(FIFO_DEPTH - 1) && push && !pop));
         row        <= (state == PRESS && press_active &&
                        col == idx_to_onehot(cur_key.col_idx)) ?
                       idx_to_onehot(cur_key.row_idx) : 4'b0000;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cur_key <= key_code_t'(fifo_dout);
                  cnt     <= CNT_W'(HOLD_CYCLES - 1);
                  state   <= PRESS;
               end
            end
            PRESS: begin
               if (cnt == '0) begin
                  cnt   <= CNT_W'(GAP_CYCLES - 1);
                  state <= GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  press_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: directed key pushes feed an expectation queue, a monitor checks each press.
// Optional bounce expectations follow KEYPAD_EMU_BOUNCE_EN.
module tb_keypad_matrix_emulator;
   import keypad_pkg::*;

   localparam int HOLD = 16;
   localparam int GAP  = 16;
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam logic [15:0] STEADY_PAT  = 16'hFFF5;
   localparam int          STEADY_HITS = 14;
`else
   localparam logic [15:0] STEADY_PAT  = 16'hFFFF;
   localparam int          STEADY_HITS = 16;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'b0000;
   logic       key_ready;
   logic [3:0] col = 4'b0000;
   logic [3:0] row;
   logic       busy;
   logic [2:0] fifo_count;
   logic       press_done;

   typedef struct {
      logic [3:0] row;
      logic [3:0] col;
      int         hits;
      bit         steady;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         col_mode = 0;
   logic [3:0] col_fixed = 4'b1000;

   always #5 clk = ~clk;

   keypad_matrix_emulator #(
      .HOLD_CYCLES   (HOLD),
      .GAP_CYCLES    (GAP),
      .FIFO_DEPTH    (4),
      .BOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .col        (col),
      .row        (row),
      .busy       (busy),
      .fifo_count (fifo_count),
      .press_done (press_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   // mode 0: sweep 1000/0100/0010/0001, 1: col_fixed, 2: illegal 0000/1100
   initial begin : col_drv
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (col_mode)
            0:       col = 4'b1000 >> ph;
            1:       col = col_fixed;
            default: col = (ph % 2 == 1) ? 4'b1100 : 4'b0000;
         endcase
         ph = (ph + 1) % 4;
      end
   end

   initial begin : monitor
      logic [3:0]  prev_col;
      logic [31:0] bits;
      int          idx, last, hits;
      bit          started;
      exp_t        e;
      prev_col = 4'b0000; bits = '0; idx = 0; last = 0; hits = 0; started = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            started = 0; hits = 0; idx = 0; last = 0; bits = '0;
         end else begin
            if (started) idx++;
            if (row != 4'b0000) begin
               if (!started) begin
                  started = 1;
                  idx = 0;
               end
               if (exp_q.size() == 0) begin
                  check("row_unexpected", {28'b0, row}, 32'h0);
               end else begin
                  check("row_value", {28'b0, row}, {28'b0, exp_q[0].row});
                  check("row_after_col", {28'b0, prev_col}, {28'b0, exp_q[0].col});
               end
               hits++;
               if (idx < 32) bits[idx] = 1'b1;
               last = idx;
            end
            if (press_done) begin
               if (exp_q.size() == 0) begin
                  fail_now("press_done_unexpected");
               end else begin
                  e = exp_q.pop_front();
                  check("hit_count", hits, e.hits);
                  if (e.steady) begin
                     check("press_pattern", {16'b0, bits[15:0]}, {16'b0, STEADY_PAT});
                     check("gap_length", idx - last, GAP);
                  end
               end
               started = 0; hits = 0; idx = 0; last = 0; bits = '0;
            end
         end
         prev_col = col;
      end
   end

   // Call at posedge+1: key_ready is stable until the next edge.
   task automatic push_key(input logic [3:0] c, input logic [3:0] r, input logic [3:0] cl,
                           input int hits, input bit steady, output int waited);
      exp_t e;
      bit   acc;
      waited    = 0;
      acc       = 0;
      key_valid = 1'b1;
      key_code  = c;
      while (!acc && waited < 400) begin
         acc = key_ready;
         @(posedge clk);
         #1;
         if (!acc) waited++;
      end
      key_valid = 1'b0;
      if (!acc) begin
         fail_now("push_timeout");
      end else begin
         e.row = r; e.col = cl; e.hits = hits; e.steady = steady;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 1500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1500) fail_now("idle_timeout");
   endtask

   initial begin : stim
      int w, n;
      repeat (3) @(posedge clk);
      #2;
      check("reset_row", {28'b0, row}, 32'h0);
      check("reset_key_ready", {31'b0, key_ready}, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_fifo_count", {29'b0, fifo_count}, 32'h0);
      check("reset_press_done", {31'b0, press_done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", {31'b0, key_ready}, 32'h0);
      @(posedge clk);
      #1;
      check("ready_after_edge", {31'b0, key_ready}, 32'h1);

      // Single KEY_8 against a column sweep.
      col_mode = 0;
      push_key(KEY_8, 4'b0010, 4'b0100, 4, 0, w);
      wait_idle();

      // KEY_1 with its column held: full hold then full gap.
      col_mode  = 1;
      col_fixed = 4'b1000;
      push_key(KEY_1, 4'b1000, 4'b1000, STEADY_HITS, 1, w);
      wait_idle();

      // Illegal strobes against a column-0 key.
      col_mode = 2;
      push_key(KEY_1, 4'b1000, 4'b1000, 0, 0, w);
      wait_idle();

      // Passcode queued behind an in-flight press; fifth key must wait.
      col_mode = 0;
      push_key(KEY_8, 4'b0010, 4'b0100, 4, 0, w);
      n = 0;
      while (!(busy && fifo_count == 3'd0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) fail_now("press_start_timeout");
      push_key(KEY_1, 4'b1000, 4'b1000, 4, 0, w);
      push_key(KEY_8, 4'b0010, 4'b0100, 4, 0, w);
      push_key(KEY_6, 4'b0100, 4'b0010, 4, 0, w);
      push_key(KEY_5, 4'b0100, 4'b0100, 4, 0, w);
      check("full_count", {29'b0, fifo_count}, 32'h4);
      check("full_not_ready", {31'b0, key_ready}, 32'h0);
      push_key(4'b1111, 4'b0001, 4'b0001, 4, 0, w);
      check("fifth_held", {31'b0, (w >= 20)}, 32'h1);
      check("refill_count", {29'b0, fifo_count}, 32'h4);
      check("refill_not_ready", {31'b0, key_ready}, 32'h0);
      wait_idle();

      // Reset mid-press with a second key queued.
      col_mode  = 1;
      col_fixed = 4'b0010;
      push_key(KEY_6, 4'b0100, 4'b0010, STEADY_HITS, 1, w);
      push_key(KEY_5, 4'b0100, 4'b0100, 0, 0, w);
      n = 0;
      while (row == 4'b0000 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) fail_now("row_timeout");
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("row_before_reset", {28'b0, row}, 32'h4);
      check("queued_before_reset", {29'b0, fifo_count}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_row", {28'b0, row}, 32'h0);
      check("async_reset_count", {29'b0, fifo_count}, 32'h0);
      check("async_reset_busy", {31'b0, busy}, 32'h0);
      check("async_reset_ready", {31'b0, key_ready}, 32'h0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rerelease_ready_low", {31'b0, key_ready}, 32'h0);
      @(posedge clk);
      #1;
      check("rerelease_ready_high", {31'b0, key_ready}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("flushed_busy", {31'b0, busy}, 32'h0);
      check("flushed_row", {28'b0, row}, 32'h0);

      // Normal operation after the abort.
      col_mode = 0;
      push_key(KEY_8, 4'b0010, 4'b0100, 4, 0, w);
      wait_idle();
      check("queue_drained", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
